// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared types and constants for the ALU command sequencer: opcodes, FSM
// state encoding and the packed command record that travels through the FIFO.
package alu_seq_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_INC  = 3'b010;
    localparam logic [2:0] OP_DEC  = 3'b011;
    localparam logic [2:0] OP_PASS = 3'b100;
    localparam logic [2:0] OP_NOT  = 3'b101;
    localparam logic [2:0] OP_OR   = 3'b110;
    localparam logic [2:0] OP_AND  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } seq_state_t;

    // 67-bit command record, laid out as {op, b, a}
    typedef struct packed {
        logic [2:0]        op;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] a;
    } cmd_t;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command and response handshake bundle between the sequencer (slave) and
// whoever issues commands and consumes results (master).
interface alu_cmd_sequencer_if;
    import alu_seq_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic [2:0]        cmd_op;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic [2:0]        rsp_op;
    logic              rsp_err;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_op, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_op, rsp_err
    );

endinterface

// File: rtl/alu_cmd_sequencer_fifo.sv
// Show-ahead synchronous FIFO holding queued ALU commands; pushes while full
// and pops while empty are ignored.
module alu_cmd_fifo
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  cmd_t                   wdata,
    output cmd_t                   rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    cmd_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the 32-bit ALU: queues commands, drives the ALU one command
// at a time and returns each result (or an ack-timeout error) in order.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int TIMEOUT   = 8
) (
    input  logic                clk,
    input  logic                rst,
    alu_cmd_sequencer_if.slave  bus,
    output logic [DATA_W-1:0]   alu_a,
    output logic [DATA_W-1:0]   alu_b,
    output logic [2:0]          alu_opcode,
    output logic                alu_enable,
    input  logic [DATA_W-1:0]   alu_result,
    input  logic                alu_ack,
    output logic                busy
);

    localparam int CW = $clog2(TIMEOUT) + 1;
    localparam int QW = $clog2(CMD_DEPTH) + 1;

    seq_state_t        state, state_n;
    logic [CW-1:0]     wait_cnt, wait_n;
    logic [DATA_W-1:0] alu_a_n, alu_b_n;
    logic [2:0]        alu_opcode_n;
    logic              alu_enable_n;
    logic              rsp_valid_q, rsp_valid_n;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_n;
    logic [2:0]        rsp_op_q, rsp_op_n;
    logic              rsp_err_q, rsp_err_n;
    logic              load_next;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [QW-1:0]     fifo_count;
    cmd_t              push_data;
    cmd_t              head;

    assign push_data = '{op: bus.cmd_op, b: bus.cmd_b, a: bus.cmd_a};

    alu_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.cmd_valid),
        .pop   (fifo_pop),
        .wdata (push_data),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bus.cmd_ready  = !fifo_full;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_op     = rsp_op_q;
    assign bus.rsp_err    = rsp_err_q;
    assign busy           = (state != ST_IDLE) || (fifo_count != '0);

    always_comb begin
        state_n      = state;
        wait_n       = wait_cnt;
        alu_a_n      = alu_a;
        alu_b_n      = alu_b;
        alu_opcode_n = alu_opcode;
        alu_enable_n = alu_enable;
        rsp_valid_n  = rsp_valid_q;
        rsp_result_n = rsp_result_q;
        rsp_op_n     = rsp_op_q;
        rsp_err_n    = rsp_err_q;
        load_next    = 1'b0;
        fifo_pop     = 1'b0;

        case (state)
            ST_IDLE: begin
                load_next = !fifo_empty;
            end
            ST_EXEC: begin
                // alu_result is only looked at while enable is high and ack is seen
                if (alu_enable && alu_ack) begin
                    rsp_result_n = alu_result;
                    rsp_err_n    = 1'b0;
                end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                    rsp_result_n = '0;
                    rsp_err_n    = 1'b1;
                end else begin
                    wait_n = wait_cnt + CW'(1);
                end
                if ((alu_enable && alu_ack) || (wait_cnt == CW'(TIMEOUT - 1))) begin
                    rsp_op_n     = alu_opcode;
                    rsp_valid_n  = 1'b1;
                    alu_enable_n = 1'b0;
                    alu_a_n      = '0;
                    alu_b_n      = '0;
                    alu_opcode_n = '0;
                    state_n      = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    load_next   = !fifo_empty;
                    if (fifo_empty) begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // Shared by IDLE and RESP so a queued command issues without an idle gap
        if (load_next) begin
            fifo_pop     = 1'b1;
            alu_a_n      = head.a;
            alu_b_n      = head.b;
            alu_opcode_n = head.op;
            alu_enable_n = 1'b1;
            wait_n       = '0;
            state_n      = ST_EXEC;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            wait_cnt     <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_opcode   <= '0;
            alu_enable   <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_op_q     <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state        <= state_n;
            wait_cnt     <= wait_n;
            alu_a        <= alu_a_n;
            alu_b        <= alu_b_n;
            alu_opcode   <= alu_opcode_n;
            alu_enable   <= alu_enable_n;
            rsp_valid_q  <= rsp_valid_n;
            rsp_result_q <= rsp_result_n;
            rsp_op_q     <= rsp_op_n;
            rsp_err_q    <= rsp_err_n;
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a combinational ALU model whose
// ack can be withheld to provoke timeouts.
module tb_alu_cmd_sequencer;
    import alu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] alu_a, alu_b, alu_result, model_res;
    logic [2:0]  alu_opcode;
    logic        alu_enable, alu_ack, busy;
    logic        ack_en = 1'b1;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    logic [31:0] got_res [16];
    logic [2:0]  got_op  [16];
    logic        got_err [16];
    int          got_cyc [16];
    int          n_got;

    localparam logic [31:0] EXP2 [8] = '{32'd15, 32'd5, 32'd11, 32'd9,
                                         32'd10, 32'hFFFF_FFF5, 32'd15, 32'd0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_cmd_sequencer_if bus();

    alu_cmd_sequencer #(.CMD_DEPTH(4), .TIMEOUT(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_enable (alu_enable),
        .alu_result (alu_result),
        .alu_ack    (alu_ack),
        .busy       (busy)
    );

    always_comb begin
        model_res = '0;
        case (alu_opcode)
            OP_ADD:  model_res = alu_a + alu_b;
            OP_SUB:  model_res = alu_a - alu_b;
            OP_INC:  model_res = alu_a + 32'd1;
            OP_DEC:  model_res = alu_a - 32'd1;
            OP_PASS: model_res = alu_a;
            OP_NOT:  model_res = ~alu_a;
            OP_OR:   model_res = alu_a | alu_b;
            OP_AND:  model_res = alu_a & alu_b;
            default: model_res = '0;
        endcase
    end

    assign alu_ack    = alu_enable & ack_en;
    assign alu_result = alu_enable ? model_res : 32'hxxxx_xxxx;

    task automatic push_cmd(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        int budget = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_op    = op;
        while (!bus.cmd_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!bus.cmd_ready) begin
            checks++;
            fails++;
            $display("[TB] FAIL push_timeout: cmd_ready=%b required 1", bus.cmd_ready);
        end
        @(posedge clk);
    endtask

    task automatic cmd_idle();
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    // Samples at negedges; a response counts when valid and ready are both high
    task automatic collect(input int n, input int budget);
        n_got = 0;
        for (int c = 0; c < budget && n_got < n; c++) begin
            if (bus.rsp_valid && bus.rsp_ready && n_got < 16) begin
                got_res[n_got] = bus.rsp_result;
                got_op[n_got]  = bus.rsp_op;
                got_err[n_got] = bus.rsp_err;
                got_cyc[n_got] = cyc;
                n_got++;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int c = 0;
        while ((busy || bus.rsp_valid) && c < 60) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if (busy || bus.rsp_valid) begin
            fails++;
            $display("[TB] FAIL idle_wait: busy=%b rsp_valid=%b required 0/0", busy, bus.rsp_valid);
        end
    endtask

    task automatic test_reset();
        bus.cmd_valid = 1'b0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.cmd_op    = '0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.cmd_ready, bus.rsp_valid, alu_enable, busy, bus.rsp_err} !== 5'b10000) begin
            fails++;
            $display("[TB] FAIL reset_flags: ready/valid/en/busy/err=%b required 10000",
                     {bus.cmd_ready, bus.rsp_valid, alu_enable, busy, bus.rsp_err});
        end
        checks++;
        if ({alu_a, alu_b, alu_opcode, bus.rsp_result, bus.rsp_op} !== '0) begin
            fails++;
            $display("[TB] FAIL reset_data: alu_a=%h alu_b=%h rsp_result=%h required 0",
                     alu_a, alu_b, bus.rsp_result);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = 32'd10;
        bus.cmd_b     = 32'd5;
        bus.cmd_op    = OP_ADD;
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (alu_enable !== 1'b1 || alu_a !== 32'd10 || bus.rsp_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL single_issue: en=%b alu_a=%0d rsp_valid=%b required 1/10/0",
                     alu_enable, alu_a, bus.rsp_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 32'd15 || bus.rsp_op !== OP_ADD
            || bus.rsp_err !== 1'b0 || alu_enable !== 1'b0) begin
            fails++;
            $display("[TB] FAIL single_rsp: valid=%b result=%0d op=%0d err=%b en=%b required 1/15/0/0/0",
                     bus.rsp_valid, bus.rsp_result, bus.rsp_op, bus.rsp_err, alu_enable);
        end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        fork
            begin
                for (int i = 0; i < 8; i++) push_cmd(32'd10, 32'd5, 3'(i));
                cmd_idle();
            end
            collect(8, 100);
        join
        checks++;
        if (n_got !== 8) begin
            fails++;
            $display("[TB] FAIL b2b_count: got %0d responses required 8", n_got);
        end
        for (int i = 0; i < 8 && i < n_got; i++) begin
            checks++;
            if (got_res[i] !== EXP2[i] || got_op[i] !== 3'(i) || got_err[i] !== 1'b0) begin
                fails++;
                $display("[TB] FAIL b2b_rsp%0d: result=%h op=%0d err=%b required %h/%0d/0",
                         i, got_res[i], got_op[i], got_err[i], EXP2[i], i);
            end
            if (i > 0) begin
                checks++;
                if (got_cyc[i] - got_cyc[i-1] !== 2) begin
                    fails++;
                    $display("[TB] FAIL b2b_spacing%0d: gap %0d cycles required 2",
                             i, got_cyc[i] - got_cyc[i-1]);
                end
            end
        end
        wait_idle();
    endtask

    task automatic test_backpressure();
        logic [2:0]  ops [6] = '{OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_PASS, OP_NOT};
        logic [31:0] exp [5] = '{32'd15, 32'd5, 32'd11, 32'd9, 32'd10};
        int acc = 0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_a     = 32'd10;
            bus.cmd_b     = 32'd5;
            bus.cmd_op    = ops[i];
            if (bus.cmd_ready) acc++;
            @(negedge clk);
        end
        checks++;
        if (acc !== 5 || bus.cmd_ready !== 1'b0) begin
            fails++;
            $display("[TB] FAIL bp_full: accepted=%0d cmd_ready=%b required 5/0", acc, bus.cmd_ready);
        end
        bus.cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 32'd15) begin
            fails++;
            $display("[TB] FAIL bp_hold: valid=%b result=%0d required 1/15", bus.rsp_valid, bus.rsp_result);
        end
        bus.rsp_ready = 1'b1;
        collect(6, 60);
        checks++;
        if (n_got !== 5) begin
            fails++;
            $display("[TB] FAIL bp_count: got %0d responses required 5", n_got);
        end
        for (int i = 0; i < 5 && i < n_got; i++) begin
            checks++;
            if (got_res[i] !== exp[i] || got_op[i] !== ops[i]) begin
                fails++;
                $display("[TB] FAIL bp_rsp%0d: result=%0d op=%0d required %0d/%0d",
                         i, got_res[i], got_op[i], exp[i], ops[i]);
            end
        end
        wait_idle();
    endtask

    task automatic test_timeout();
        int en_cnt = 0;
        ack_en = 1'b0;
        push_cmd(32'd1, 32'd2, OP_ADD);
        cmd_idle();
        for (int c = 0; c < 40; c++) begin
            if (bus.rsp_valid) break;
            if (alu_enable) en_cnt++;
            @(negedge clk);
        end
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_result !== 32'd0
            || en_cnt !== 8 || alu_enable !== 1'b0) begin
            fails++;
            $display("[TB] FAIL timeout_rsp: valid=%b err=%b result=%0d exec_cycles=%0d en=%b required 1/1/0/8/0",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_result, en_cnt, alu_enable);
        end
        ack_en = 1'b1;
        push_cmd(32'd7, 32'd3, OP_SUB);
        cmd_idle();
        collect(1, 20);
        checks++;
        if (n_got !== 1 || got_res[0] !== 32'd4 || got_err[0] !== 1'b0) begin
            fails++;
            $display("[TB] FAIL timeout_recover: count=%0d result=%0d err=%b required 1/4/0",
                     n_got, got_res[0], got_err[0]);
        end
        wait_idle();
    endtask

    task automatic test_reset_mid_exec();
        ack_en = 1'b0;
        push_cmd(32'd1, 32'd1, OP_ADD);
        push_cmd(32'd2, 32'd2, OP_ADD);
        push_cmd(32'd3, 32'd3, OP_ADD);
        cmd_idle();
        checks++;
        if (alu_enable !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("[TB] FAIL rst_pre: en=%b busy=%b required 1/1", alu_enable, busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({alu_enable, bus.rsp_valid, busy, bus.cmd_ready} !== 4'b0001) begin
            fails++;
            $display("[TB] FAIL rst_async: en/valid/busy/ready=%b required 0001",
                     {alu_enable, bus.rsp_valid, busy, bus.cmd_ready});
        end
        @(negedge clk);
        rst    = 1'b0;
        ack_en = 1'b1;
        collect(1, 30);
        checks++;
        if (n_got !== 0 || busy !== 1'b0) begin
            fails++;
            $display("[TB] FAIL rst_discard: responses=%0d busy=%b required 0/0", n_got, busy);
        end
    endtask

    task automatic test_push_pop_same_cycle();
        logic [31:0] exp [5] = '{32'd5, 32'd15, 32'd4, 32'd21, 32'hFFFF_FFFF};
        bus.rsp_ready = 1'b0;
        push_cmd(32'd1, 32'd1, OP_ADD);
        push_cmd(32'd9, 32'd4, OP_SUB);
        push_cmd(32'd12, 32'd3, OP_OR);
        push_cmd(32'd12, 32'd6, OP_AND);
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 32'd2 || bus.cmd_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL pp_setup: valid=%b result=%0d ready=%b required 1/2/1",
                     bus.rsp_valid, bus.rsp_result, bus.cmd_ready);
        end
        bus.cmd_a     = 32'd20;
        bus.cmd_b     = 32'd0;
        bus.cmd_op    = OP_INC;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (alu_enable !== 1'b1 || alu_a !== 32'd9 || bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL pp_direct_exec: en=%b alu_a=%0d valid=%b ready=%b required 1/9/0/1",
                     alu_enable, alu_a, bus.rsp_valid, bus.cmd_ready);
        end
        bus.cmd_a  = 32'd0;
        bus.cmd_op = OP_NOT;
        @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b0) begin
            fails++;
            $display("[TB] FAIL pp_count: cmd_ready=%b required 0 after one more push", bus.cmd_ready);
        end
        bus.cmd_valid = 1'b0;
        collect(6, 60);
        checks++;
        if (n_got !== 5) begin
            fails++;
            $display("[TB] FAIL pp_drain_count: got %0d responses required 5", n_got);
        end
        for (int i = 0; i < 5 && i < n_got; i++) begin
            checks++;
            if (got_res[i] !== exp[i] || got_err[i] !== 1'b0) begin
                fails++;
                $display("[TB] FAIL pp_rsp%0d: result=%h err=%b required %h/0", i, got_res[i], got_err[i], exp[i]);
            end
        end
        wait_idle();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_timeout();
        test_reset_mid_exec();
        test_push_pop_same_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Upstream issue stage for the 32-bit ALU (A, B, 3-bit opcode, enable in; result, ack out).
- Accepts operand/opcode commands over a valid/ready interface and buffers them in a small FIFO.
- Drives the ALU one command at a time, asserting enable, and captures result on ack.
- Returns each result on a valid/ready response port, flagging an error if ack never arrives.

Parameters:
CMD_DEPTH, 4, command FIFO entries (power of two, >=2)
TIMEOUT, 8, max cycles in EXEC waiting for ack before error (>=1)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
cmd_valid  input  1  command offered
cmd_ready  output  1  FIFO not full
cmd_a  input  32  operand A
cmd_b  input  32  operand B
cmd_op  input  3  ALU opcode
alu_a  output  32  to ALU A
alu_b  output  32  to ALU B
alu_opcode  output  3  to ALU opcode
alu_enable  output  1  to ALU enable
alu_result  input  32  from ALU result (tri-stated by ALU when enable low)
alu_ack  input  1  from ALU ack
rsp_valid  output  1  response available
rsp_ready  input  1  response consumer ready
rsp_result  output  32  captured result
rsp_op  output  3  opcode of this response
rsp_err  output  1  ack timeout on this response
busy  output  1  FSM not IDLE or FIFO not empty

Behaviour:
- Reset values: all outputs 0 except cmd_ready=1. FIFO pointers and count 0, FSM IDLE. Reset applies immediately on rst high, including mid-EXEC: alu_enable drops asynchronously and the in-flight command and all queued commands are discarded.
- Command push on a clock edge with cmd_valid && cmd_ready. cmd_ready = !full.
  - No bypass: a push while full is ignored even if a pop occurs in the same cycle.
  - Simultaneous push and pop when not full leaves count unchanged.
- FSM states: IDLE, EXEC, RESP. All ALU drive outputs are registered.
- IDLE:
  - If FIFO is non-empty: pop the head, load alu_a/alu_b/alu_opcode, set alu_enable=1, go to EXEC, clear the wait counter.
  - Otherwise stay.
- EXEC:
  - alu_enable=1. At each edge, sample alu_ack.
  - If ack=1: capture alu_result into rsp_result, rsp_op=alu_opcode, rsp_err=0, rsp_valid=1. Drop alu_enable and zero alu_a/b/opcode. Go to RESP.
  - Else increment the wait counter. When the counter reaches TIMEOUT-1 with no ack: rsp_result=0, rsp_err=1, rsp_valid=1, go to RESP.
- RESP:
  - Hold rsp_* stable while rsp_valid && !rsp_ready.
  - On rsp_ready:
    - If FIFO is non-empty, pop and go directly to EXEC (same loading as from IDLE) with rsp_valid=0.
    - Else go to IDLE with rsp_valid=0.
- alu_result is never sampled while alu_enable is low; X/Z on alu_result outside EXEC must not propagate.
- Latency:
  - Command pushed at edge N into an empty, IDLE block: alu_enable high after edge N+1; rsp_valid high after edge N+2 (ack is combinational in the ALU).
  - Steady-state throughput with rsp_ready held high: one response per 2 cycles.
- Widths: operands are passed unmodified. Wait counter width is clog2(TIMEOUT)+1. FIFO count width is clog2(CMD_DEPTH)+1.
- Responses are returned in command order; exactly one response per accepted command (unless reset intervenes).

Decomposition:
- Shared package alu_seq_pkg:
  - Opcode constants OP_ADD=000, OP_SUB=001, OP_INC=010, OP_DEC=011, OP_PASS=100, OP_NOT=101, OP_OR=110, OP_AND=111.
  - FSM state encoding (IDLE, EXEC, RESP).
  - Data width constant 32.
  - Command record layout {op, b, a} = 67 bits.
- One sub-module: alu_cmd_fifo.
  - Synchronous FIFO, CMD_DEPTH x 67 bits.
  - Ports: push, pop, full, empty, count.
  - Uses the same clk and async rst.

Test Plan:
1. Reset, push {A=10, B=5, op=000} with rsp_ready=1 -> alu_enable high one cycle later; rsp_valid 2 cycles after push with rsp_result=15, rsp_op=000, rsp_err=0.
2. Push all 8 opcodes with A=10, B=5 back-to-back -> in-order results 15, 5, 11, 9, 10, 0xFFFFFFF5, 15, 0; rsp_valid every 2nd cycle.
3. Hold rsp_ready=0 and push 6 commands -> cmd_ready falls after 4 are queued plus 1 in flight. rsp_result stays 15 while stalled. Releasing rsp_ready drains all 5 in order; the 6th is never accepted unless re-offered.
4. ALU model with ack forced 0 -> after TIMEOUT (8) EXEC cycles, rsp_valid=1, rsp_err=1, rsp_result=0. The next command then completes normally with rsp_err=0.
5. Assert rst during EXEC with 2 commands queued -> alu_enable, rsp_valid and busy are 0 immediately; cmd_ready=1; no response is emitted for the discarded commands after release.
6. Push and response pop in the same cycle with FIFO at 3 entries -> count stays 3; cmd_ready stays 1; the next EXEC starts without passing through IDLE.
